// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: glyph patterns (active-low, g..a), capture FSM states,
// and a pattern decoder reusable by the display driver's bench.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_A     = 7'b000_1000;
  localparam logic [6:0] SEG_B     = 7'b000_0011;
  localparam logic [6:0] SEG_C     = 7'b100_0110;
  localparam logic [6:0] SEG_D     = 7'b010_0001;
  localparam logic [6:0] SEG_E     = 7'b000_0110;
  localparam logic [6:0] SEG_F     = 7'b000_1110;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seg_state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] pattern);
    seg_dec_t r;
    r = '{legal: 1'b1, blank: 1'b0, nibble: 4'h0};
    case (pattern)
      SEG_0:     r.nibble = 4'h0;
      SEG_1:     r.nibble = 4'h1;
      SEG_2:     r.nibble = 4'h2;
      SEG_3:     r.nibble = 4'h3;
      SEG_4:     r.nibble = 4'h4;
      SEG_5:     r.nibble = 4'h5;
      SEG_6:     r.nibble = 4'h6;
      SEG_7:     r.nibble = 4'h7;
      SEG_8:     r.nibble = 4'h8;
      SEG_9:     r.nibble = 4'h9;
      SEG_A:     r.nibble = 4'hA;
      SEG_B:     r.nibble = 4'hB;
      SEG_C:     r.nibble = 4'hC;
      SEG_D:     r.nibble = 4'hD;
      SEG_E:     r.nibble = 4'hE;
      SEG_F:     r.nibble = 4'hF;
      SEG_BLANK: begin r.legal = 1'b0; r.blank = 1'b1; end
      default:   r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_sync2.sv
// Two-flop synchronizer, W bits wide; flops preset to all-ones (idle active-low bus).
// Latency 2 cycles, no backpressure.
module seg_sync2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 7-segment display: debounces each digit slot and decodes its glyph.
// Optional macro SEG_SCAN_DP_EN adds a decimal-point input and per-digit dp_o capture.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  DIGIT_MASK     = 8'b0111_0111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
`ifdef SEG_SCAN_DP_EN
  input  logic        seg_dp_in,
  output logic [7:0]  dp_o,
`endif
  input  logic [7:0]  dig_in,
  output logic [31:0] digits_o,
  output logic [7:0]  valid_o,
  output logic [7:0]  err_o,
  output logic        frame_o,
  output logic        multi_o,
  output logic        stale_o
);

`ifdef SEG_SCAN_DP_EN
  localparam int unsigned PAT_W = 8;
`else
  localparam int unsigned PAT_W = 7;
`endif
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

  logic [PAT_W-1:0] pat_raw;
  logic [PAT_W-1:0] pat_s;
  logic [7:0]       dig_s;

`ifdef SEG_SCAN_DP_EN
  assign pat_raw = {seg_dp_in, seg_in};
`else
  assign pat_raw = seg_in;
`endif

  seg_sync2 #(.W(PAT_W)) u_sync_seg (.clk(clk), .rst(rst), .d_i(pat_raw), .q_o(pat_s));
  seg_sync2 #(.W(8))     u_sync_dig (.clk(clk), .rst(rst), .d_i(dig_in),  .q_o(dig_s));

  seg_state_e       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      digits_q, digits_d;
  logic [7:0]       valid_q, valid_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       seen_q, seen_d;
  logic             frame_q, frame_d;
  logic             multi_q, multi_d;
  logic             stale_q, stale_d;
  logic [31:0]      tmo_q, tmo_d;
`ifdef SEG_SCAN_DP_EN
  logic [7:0]       dp_q, dp_d;
`endif

  logic [7:0] dig_low;
  logic       none_sel, single_sel, multi_sel;
  logic [2:0] sel_idx;
  logic       match;
  logic       start;
  logic       cap;
  logic [7:0] cap_mask;
  seg_dec_t   dec;

  // A power-of-two test on the low selects distinguishes none / exactly one / several.
  assign dig_low    = ~dig_s;
  assign none_sel   = (dig_low == 8'h00);
  assign single_sel = !none_sel && ((dig_low & (dig_low - 8'd1)) == 8'h00);
  assign multi_sel  = !none_sel && !single_sel;

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (dig_low[i]) sel_idx = 3'(i);
    end
  end

  assign match = (sel_idx == idx_q) && (pat_s == pat_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    cap     = 1'b0;
    if (multi_sel || none_sel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   start = 1'b1;
        SETTLE: begin
          if (!match) begin
            start = 1'b1;
          end else if (cnt_q >= STABLE_LAST) begin
            cap     = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        HOLD:    start = !match;
        default: state_d = IDLE;
      endcase
    end
    if (start) begin
      state_d = SETTLE;
      idx_d   = sel_idx;
      pat_d   = pat_s;
      cnt_d   = 16'd1;
    end
  end

  assign dec = seg_decode(pat_q[6:0]);

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    cap_mask = 8'h00;
`ifdef SEG_SCAN_DP_EN
    dp_d     = dp_q;
`endif
    if (cap) begin
      cap_mask = 8'h01 << idx_q;
      if (dec.legal) begin
        digits_d[{idx_q, 2'b00} +: 4] = dec.nibble;
        valid_d[idx_q] = 1'b1;
        err_d[idx_q]   = 1'b0;
      end else if (dec.blank) begin
        valid_d[idx_q] = 1'b0;
        err_d[idx_q]   = 1'b0;
      end else begin
        valid_d[idx_q] = 1'b0;
        err_d[idx_q]   = 1'b1;
      end
`ifdef SEG_SCAN_DP_EN
      dp_d[idx_q] = ~pat_q[7];
`endif
    end
    // A capture coinciding with the frame clear survives into the next frame.
    frame_d = ((seen_q & DIGIT_MASK) == DIGIT_MASK);
    seen_d  = (frame_d ? 8'h00 : seen_q) | cap_mask;
    multi_d = multi_q | multi_sel;
    if (cap) begin
      tmo_d   = 32'd0;
      stale_d = 1'b0;
    end else begin
      tmo_d   = (tmo_q >= TIMEOUT_CYCLES) ? tmo_q : tmo_q + 32'd1;
      stale_d = (tmo_q >= TIMEOUT_CYCLES);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      pat_q    <= '1;
      cnt_q    <= 16'd0;
      digits_q <= 32'd0;
      valid_q  <= 8'h00;
      err_q    <= 8'h00;
      seen_q   <= 8'h00;
      frame_q  <= 1'b0;
      multi_q  <= 1'b0;
      stale_q  <= 1'b0;
      tmo_q    <= 32'd0;
`ifdef SEG_SCAN_DP_EN
      dp_q     <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      multi_q  <= multi_d;
      stale_q  <= stale_d;
      tmo_q    <= tmo_d;
`ifdef SEG_SCAN_DP_EN
      dp_q     <= dp_d;
`endif
    end
  end

  assign digits_o = digits_q;
  assign valid_o  = valid_q;
  assign err_o    = err_q;
  assign frame_o  = frame_q;
  assign multi_o  = multi_q;
  assign stale_o  = stale_q;
`ifdef SEG_SCAN_DP_EN
  assign dp_o     = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: scoreboard of expected per-digit captures, checked after each digit dwell.
module tb_seg_scan_capture;

  localparam int unsigned STABLE  = 20;
  localparam int unsigned TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [7:0]  dig_in = 8'hFF;
  logic [31:0] digits_o;
  logic [7:0]  valid_o, err_o;
  logic        frame_o, multi_o, stale_o;
`ifdef SEG_SCAN_DP_EN
  logic        seg_dp_in = 1'b1;
  logic [7:0]  dp_o;
`endif

  seg_scan_capture #(
    .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT), .DIGIT_MASK(8'b0111_0111)
  ) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in),
`ifdef SEG_SCAN_DP_EN
    .seg_dp_in(seg_dp_in), .dp_o(dp_o),
`endif
    .dig_in(dig_in), .digits_o(digits_o), .valid_o(valid_o), .err_o(err_o),
    .frame_o(frame_o), .multi_o(multi_o), .stale_o(stale_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [3:0] nib;
    logic       legal;
    logic       blank;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          frame_cnt = 0;
  logic [31:0] m_dig = 32'h0;
  logic [7:0]  m_val = 8'h00;
  logic [7:0]  m_err = 8'h00;

  always @(negedge clk) if (frame_o === 1'b1) frame_cnt++;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // Drive one digit slot for a full dwell and record what the receiver should conclude.
  task automatic drive_digit(input int idx, input logic [6:0] pat);
    exp_t e;
    e.idx = idx; e.nib = 4'h0; e.legal = 1'b0; e.blank = (pat == 7'h7F);
    for (int v = 0; v < 16; v++) begin
      if (glyph(4'(v)) == pat) begin e.legal = 1'b1; e.nib = 4'(v); end
    end
    sb.push_back(e);
    dig_in = ~(8'h01 << idx);
    seg_in = pat;
    repeat (STABLE + 5) @(posedge clk);
    #1;
  endtask

  task automatic blank_gap();
    dig_in = 8'hFF;
    seg_in = 7'h7F;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic retire();
    exp_t e;
    e = sb.pop_front();
    if (e.legal) begin
      m_dig[e.idx*4 +: 4] = e.nib; m_val[e.idx] = 1'b1; m_err[e.idx] = 1'b0;
    end else if (e.blank) begin
      m_val[e.idx] = 1'b0; m_err[e.idx] = 1'b0;
    end else begin
      m_val[e.idx] = 1'b0; m_err[e.idx] = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (990) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (stale_o !== 1'b0) begin miscompares++; $display("FAIL stale_early got=%b exp=0", stale_o); end
    repeat (13) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (stale_o !== 1'b1) begin miscompares++; $display("FAIL stale_at_1003 got=%b exp=1", stale_o); end
    repeat (997) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({digits_o, valid_o, err_o, multi_o} !== 49'h0 || frame_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_idle got=%h/%h/%h/%b frames=%0d exp=0", digits_o, valid_o, err_o, multi_o, frame_cnt);
    end
  endtask

  task automatic test_single();
    drive_digit(0, 7'b100_0000);
    retire();
    vectors++;
    if (digits_o[3:0] !== 4'h0 || valid_o !== m_val) begin
      miscompares++; $display("FAIL single_d0 got=%h/%h exp=%h/%h", digits_o[3:0], valid_o, 4'h0, m_val);
    end
    vectors++;
    if (stale_o !== 1'b0) begin miscompares++; $display("FAIL stale_clear got=%b exp=0", stale_o); end
    drive_digit(1, 7'b001_1001);
    retire();
    vectors++;
    if (digits_o !== m_dig || valid_o !== m_val) begin
      miscompares++; $display("FAIL direct_d1 got=%h/%h exp=%h/%h", digits_o, valid_o, m_dig, m_val);
    end
    blank_gap();
  endtask

  task automatic test_full_scan();
    int idxs[6];
    logic [3:0] vals[6];
    int f0;
    idxs = '{0, 1, 2, 4, 5, 6};
    vals = '{4'h0, 4'h8, 4'h4, 4'h0, 4'h4, 4'h6};
    f0 = frame_cnt;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 6; k++) begin
        drive_digit(idxs[k], glyph(vals[k]));
        retire();
        vectors++;
        if (digits_o !== m_dig || valid_o !== m_val || err_o !== m_err) begin
          miscompares++;
          $display("FAIL scan_d%0d got=%h/%h/%h exp=%h/%h/%h", idxs[k], digits_o, valid_o, err_o, m_dig, m_val, m_err);
        end
        blank_gap();
      end
    end
    vectors++;
    if (digits_o !== 32'h0640_0480) begin miscompares++; $display("FAIL scan_value got=%h exp=06400480", digits_o); end
    vectors++;
    if (frame_cnt - f0 != 2) begin miscompares++; $display("FAIL scan_frames got=%0d exp=2", frame_cnt - f0); end
  endtask

  task automatic test_unstable();
    int f0;
    f0 = frame_cnt;
    dig_in = 8'b1111_1101;
    for (int t = 0; t < 8; t++) begin
      seg_in = (t % 2 == 0) ? glyph(4'h0) : glyph(4'h3);
      repeat (STABLE - 1) @(posedge clk);
      #1;
    end
    blank_gap();
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (digits_o[7:4] !== m_dig[7:4] || valid_o[1] !== m_val[1]) begin
      miscompares++; $display("FAIL unstable_d1 got=%h/%b exp=%h/%b", digits_o[7:4], valid_o[1], m_dig[7:4], m_val[1]);
    end
    vectors++;
    if (frame_cnt != f0) begin miscompares++; $display("FAIL unstable_frame got=%0d exp=%0d", frame_cnt, f0); end
  endtask

  task automatic test_multi();
    dig_in = 8'b1111_1100;
    seg_in = glyph(4'h1);
    repeat (10) @(posedge clk);
    #1;
    blank_gap();
    @(negedge clk);
    vectors++;
    if (multi_o !== 1'b1 || digits_o !== m_dig || valid_o !== m_val) begin
      miscompares++; $display("FAIL multi_set got=%b/%h/%h exp=1/%h/%h", multi_o, digits_o, valid_o, m_dig, m_val);
    end
    drive_digit(7, glyph(4'hA));
    retire();
    vectors++;
    if (digits_o !== m_dig || valid_o !== m_val || multi_o !== 1'b1) begin
      miscompares++; $display("FAIL multi_after got=%h/%h/%b exp=%h/%h/1", digits_o, valid_o, multi_o, m_dig, m_val);
    end
    blank_gap();
  endtask

  task automatic test_err_and_reset();
    drive_digit(2, 7'b111_0000);
    retire();
    vectors++;
    if (err_o[2] !== 1'b1 || valid_o[2] !== 1'b0 || digits_o !== m_dig) begin
      miscompares++; $display("FAIL err_d2 got=%b/%b/%h exp=1/0/%h", err_o[2], valid_o[2], digits_o, m_dig);
    end
    blank_gap();
    drive_digit(2, glyph(4'h9));
    retire();
    vectors++;
    if (err_o[2] !== 1'b0 || digits_o[11:8] !== 4'h9 || valid_o !== m_val) begin
      miscompares++; $display("FAIL recover_d2 got=%b/%h/%h exp=0/9/%h", err_o[2], digits_o[11:8], valid_o, m_val);
    end
    blank_gap();
    drive_digit(0, 7'h7F);
    retire();
    vectors++;
    if (valid_o !== m_val || err_o !== m_err || digits_o !== m_dig) begin
      miscompares++; $display("FAIL blank_d0 got=%h/%h/%h exp=%h/%h/%h", valid_o, err_o, digits_o, m_val, m_err, m_dig);
    end
    blank_gap();
    dig_in = 8'b1110_1111;
    seg_in = glyph(4'h5);
    repeat (STABLE / 2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({digits_o, valid_o, err_o, frame_o, multi_o, stale_o} !== 51'h0) begin
      miscompares++;
      $display("FAIL mid_reset got=%h/%h/%h/%b%b%b exp=0", digits_o, valid_o, err_o, frame_o, multi_o, stale_o);
    end
    blank_gap();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_scan();
    test_unstable();
    test_multi();
    test_err_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
